// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester and RAM-side signal bundle for ram_arbiter.
//   m0_*/m1_* : request fields (req, we, lock, adr, wdata) in; gnt, rvalid, rdata out
//   ram_*     : enable/rw/adr/in out to the RAM; ram_out read data back in
// Modports: slave = arbiter view, master = requester/RAM environment view.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic              m0_lock;
    logic [ADDR_W-1:0] m0_adr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_adr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              ram_enable;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_in;
    logic [DATA_W-1:0] ram_out;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_adr, m0_wdata,
        input  m1_req, m1_we, m1_lock, m1_adr, m1_wdata,
        input  ram_out,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_enable, ram_rw, ram_adr, ram_in
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_adr, m0_wdata,
        output m1_req, m1_we, m1_lock, m1_adr, m1_wdata,
        output ram_out,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_enable, ram_rw, ram_adr, ram_in
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester single-port RAM arbiter with bus locking,
// boot-mode restriction and a pipelined read-return path.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ce          : clock enable; when low no grant is issued
//   boot_mode   : only M0 may be granted while high
//   bus         : ram_arbiter_if.slave (requesters M0/M1 and RAM side)
// Optional feature: define RAM_ARBITER_RR_EN for round-robin IDLE
// contention; otherwise M0 always wins.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         boot_mode,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_xfer;
    logic              w_m1_first;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_adr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic              r_ram_enable;
    logic              r_ram_rw;
    logic [ADDR_W-1:0] r_ram_adr;
    logic [DATA_W-1:0] r_ram_in;
    logic              r_s1_rd;
    logic              r_s1_id;
    logic              r_s2_rd;
    logic              r_s2_id;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

`ifdef RAM_ARBITER_RR_EN
    logic r_prio;  // 1: M1 has priority in IDLE contention

    // Priority goes to whichever requester was not granted last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_xfer) begin
            r_prio <= w_gnt0;
        end
    end

    assign w_m1_first = r_prio;
`else
    assign w_m1_first = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant decode and next state; grants are gated by reset so they read 0 in reset.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;

        if (rst_n && ce) begin
            case (r_state)
                IDLE: begin
                    if (boot_mode) begin
                        w_gnt0 = bus.m0_req;
                    end else if (bus.m0_req && bus.m1_req) begin
                        w_gnt0 = !w_m1_first;
                        w_gnt1 = w_m1_first;
                    end else begin
                        w_gnt0 = bus.m0_req;
                        w_gnt1 = bus.m1_req;
                    end
                end
                LOCK0:   w_gnt0 = bus.m0_req;
                LOCK1:   w_gnt1 = bus.m1_req && !boot_mode;
                default: ;
            endcase
        end

        case (r_state)
            IDLE: begin
                if (w_gnt0 && bus.m0_lock) begin
                    w_state_nxt = LOCK0;
                end else if (w_gnt1 && bus.m1_lock) begin
                    w_state_nxt = LOCK1;
                end
            end
            LOCK0: begin
                if (ce && !bus.m0_lock && (w_gnt0 || !bus.m0_req)) begin
                    w_state_nxt = IDLE;
                end
            end
            LOCK1: begin
                // Boot mode forcibly breaks an M1 lock.
                if (boot_mode) begin
                    w_state_nxt = IDLE;
                end else if (ce && !bus.m1_lock && (w_gnt1 || !bus.m1_req)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_xfer      = w_gnt0 || w_gnt1;
    assign w_sel_we    = w_gnt0 ? bus.m0_we    : bus.m1_we;
    assign w_sel_adr   = w_gnt0 ? bus.m0_adr   : bus.m1_adr;
    assign w_sel_wdata = w_gnt0 ? bus.m0_wdata : bus.m1_wdata;

    // Access stage, read tag pipeline and read-data return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_enable <= 1'b0;
            r_ram_rw     <= 1'b0;
            r_ram_adr    <= '0;
            r_ram_in     <= '0;
            r_s1_rd      <= 1'b0;
            r_s1_id      <= 1'b0;
            r_s2_rd      <= 1'b0;
            r_s2_id      <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_ram_enable <= w_xfer;
            if (w_xfer) begin
                r_ram_rw  <= w_sel_we;
                r_ram_adr <= w_sel_adr;
                r_ram_in  <= w_sel_wdata;
            end
            r_s1_rd   <= w_xfer && !w_sel_we;
            r_s1_id   <= w_gnt1;
            r_s2_rd   <= r_s1_rd;
            r_s2_id   <= r_s1_id;
            r_rvalid0 <= r_s2_rd && !r_s2_id;
            r_rvalid1 <= r_s2_rd && r_s2_id;
            if (r_s2_rd && !r_s2_id) begin
                r_rdata0 <= bus.ram_out;
            end
            if (r_s2_rd && r_s2_id) begin
                r_rdata1 <= bus.ram_out;
            end
        end
    end

    assign bus.m0_gnt     = w_gnt0;
    assign bus.m1_gnt     = w_gnt1;
    assign bus.m0_rvalid  = r_rvalid0;
    assign bus.m1_rvalid  = r_rvalid1;
    assign bus.m0_rdata   = r_rdata0;
    assign bus.m1_rdata   = r_rdata1;
    assign bus.ram_enable = r_ram_enable;
    assign bus.ram_rw     = r_ram_rw;
    assign bus.ram_adr    = r_ram_adr;
    assign bus.ram_in     = r_ram_in;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scoreboard bench for ram_arbiter.
// Stimulus pushes expected RAM accesses and read returns into queues; a
// negedge monitor pops and compares whenever the DUT strobes ram_enable or rvalid.
// Unwritten RAM locations read as (adr ^ 8'hB7), so 0x12 holds 0xA5.
module tb_ram_arbiter;

    typedef struct packed {
        logic        rw;
        logic [7:0]  adr;
        logic [7:0]  wd;
        logic [31:0] c;
    } ram_exp_t;

    typedef struct packed {
        logic [7:0]  d;
        logic [31:0] c;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ce;
    logic boot_mode;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rv_seen;

    ram_exp_t qram[$];
    rd_exp_t  q0[$];
    rd_exp_t  q1[$];
    ram_exp_t er;
    rd_exp_t  ed;

    bit [7:0] mem [256];
    bit       wr  [256];

    ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .boot_mode (boot_mode),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.ram_enable) begin
            if (bus.ram_rw) begin
                mem[bus.ram_adr] <= bus.ram_in;
                wr[bus.ram_adr]  <= 1'b1;
            end else begin
                bus.ram_out <= wr[bus.ram_adr] ? mem[bus.ram_adr] : (bus.ram_adr ^ 8'hB7);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string nm);
        total++;
        bad++;
        $display("FAIL %s: unexpected strobe at cycle %0d", nm, cyc);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus.ram_enable) begin
            if (qram.size() == 0) unexp("ram_enable");
            else begin
                er = qram.pop_front();
                chk("ram_rw", 32'(bus.ram_rw), 32'(er.rw));
                chk("ram_adr", 32'(bus.ram_adr), 32'(er.adr));
                if (er.rw) chk("ram_in", 32'(bus.ram_in), 32'(er.wd));
                chk("ram_cyc", 32'(cyc), er.c);
            end
        end
        if (bus.m0_rvalid) begin
            if (q0.size() == 0) unexp("m0_rvalid");
            else begin
                ed = q0.pop_front();
                chk("m0_rdata", 32'(bus.m0_rdata), 32'(ed.d));
                chk("m0_rv_cyc", 32'(cyc), ed.c);
            end
        end
        if (bus.m1_rvalid) begin
            if (q1.size() == 0) unexp("m1_rvalid");
            else begin
                ed = q1.pop_front();
                chk("m1_rdata", 32'(bus.m1_rdata), 32'(ed.d));
                chk("m1_rv_cyc", 32'(cyc), ed.c);
            end
        end
    end

    task automatic set_m(input int n, input logic req, input logic we, input logic lock,
                         input logic [7:0] adr, input logic [7:0] wd);
        if (n == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock;
            bus.m0_adr = adr; bus.m0_wdata = wd;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock;
            bus.m1_adr = adr; bus.m1_wdata = wd;
        end
    endtask

    // One cycle: check grants, push expectations for the expected winner.
    task automatic tick(input logic e0, input logic e1, input logic [7:0] r0,
                        input logic [7:0] r1, input string nm);
        @(negedge clk);
        chk({nm, "_gnt0"}, 32'(bus.m0_gnt), 32'(e0));
        chk({nm, "_gnt1"}, 32'(bus.m1_gnt), 32'(e1));
        if (e0) begin
            qram.push_back({bus.m0_we, bus.m0_adr, bus.m0_wdata, 32'(cyc + 1)});
            if (!bus.m0_we) q0.push_back({r0, 32'(cyc + 3)});
        end
        if (e1) begin
            qram.push_back({bus.m1_we, bus.m1_adr, bus.m1_wdata, 32'(cyc + 1)});
            if (!bus.m1_we) q1.push_back({r1, 32'(cyc + 3)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 8'h00, nm);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt0"}, 32'(bus.m0_gnt), 32'h0);
        chk({nm, "_gnt1"}, 32'(bus.m1_gnt), 32'h0);
        chk({nm, "_en"}, 32'(bus.ram_enable), 32'h0);
        chk({nm, "_rw"}, 32'(bus.ram_rw), 32'h0);
        chk({nm, "_adr"}, 32'(bus.ram_adr), 32'h0);
        chk({nm, "_in"}, 32'(bus.ram_in), 32'h0);
        chk({nm, "_rv0"}, 32'(bus.m0_rvalid), 32'h0);
        chk({nm, "_rv1"}, 32'(bus.m1_rvalid), 32'h0);
        chk({nm, "_rd0"}, 32'(bus.m0_rdata), 32'h0);
        chk({nm, "_rd1"}, 32'(bus.m1_rdata), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        ce = 1'b1;
        boot_mode = 1'b0;
        bus.ram_out = 8'h00;
        set_m(0, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00);
        set_m(1, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00);

        // Reset state, with requests pending.
        repeat (2) @(negedge clk);
        chk_zero("rst");
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Contention for four cycles.
        set_m(0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        set_m(1, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
`ifdef RAM_ARBITER_RR_EN
        tick(1'b1, 1'b0, 8'h97, 8'h87, "cont0");
        tick(1'b0, 1'b1, 8'h97, 8'h87, "cont1");
        tick(1'b1, 1'b0, 8'h97, 8'h87, "cont2");
        tick(1'b0, 1'b1, 8'h97, 8'h87, "cont3");
`else
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'h97, 8'h87, "cont");
`endif
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        idle(4, "cont_drain");

        // Single read of 0x12 -> 0xA5, rdata then holds.
        set_m(0, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00);
        tick(1'b1, 1'b0, 8'hA5, 8'h00, "rd");
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        idle(5, "rd_drain");
        chk("rd_hold", 32'(bus.m0_rdata), 32'hA5);

        // Lock: M1 locked write, M0 blocked until M1 unlocks.
        set_m(1, 1'b1, 1'b1, 1'b1, 8'h50, 8'h40);
        tick(1'b0, 1'b1, 8'h00, 8'h00, "lk_w");
        set_m(1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        set_m(0, 1'b1, 1'b0, 1'b0, 8'h50, 8'h00);
        idle(2, "lk_hold");
        set_m(1, 1'b1, 1'b1, 1'b0, 8'h51, 8'h41);
        tick(1'b0, 1'b1, 8'h00, 8'h00, "lk_rel");
        set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick(1'b1, 1'b0, 8'h40, 8'h00, "lk_m0");
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        idle(4, "lk_drain");

        // Boot mode: M1 alone is never granted.
        boot_mode = 1'b1;
        set_m(1, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 8'h00, 8'h00, "boot");
            chk("boot_en", 32'(bus.ram_enable), 32'h0);
        end
        boot_mode = 1'b0;
        tick(1'b0, 1'b1, 8'h00, 8'h87, "boot_off");
        // Boot mode rising inside LOCK1 drops the lock.
        set_m(1, 1'b1, 1'b1, 1'b1, 8'h60, 8'h5A);
        tick(1'b0, 1'b1, 8'h00, 8'h00, "bl_w");
        boot_mode = 1'b1;
        set_m(1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        set_m(0, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00);
        tick(1'b0, 1'b0, 8'h00, 8'h00, "bl_lk");
        tick(1'b1, 1'b0, 8'hA5, 8'h00, "bl_m0");
        boot_mode = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        idle(4, "bl_drain");

        // ce stall after a granted read; the read still returns at T3.
        set_m(0, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00);
        tick(1'b1, 1'b0, 8'hA5, 8'h00, "ce_rd");
        ce = 1'b0;
        set_m(0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        set_m(1, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
        idle(2, "ce_stall");
        ce = 1'b1;
        set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick(1'b1, 1'b0, 8'h97, 8'h00, "ce_resume");
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        idle(4, "ce_drain");

        // Reset in the cycle after a granted read discards it.
        set_m(0, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00);
        tick(1'b1, 1'b0, 8'hA5, 8'h00, "rr_rd");
        rst_n = 1'b0;
        qram.delete();
        q0.delete();
        @(negedge clk);
        chk_zero("rr_in");
        @(posedge clk);
        #1;
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk_zero("rr_in2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.m0_rvalid || bus.m1_rvalid) rv_seen++;
        end
        chk("rr_no_rvalid", 32'(rv_seen), 32'h0);

        chk("q_ram_empty", 32'(qram.size()), 32'h0);
        chk("q_m0_empty", 32'(q0.size()), 32'h0);
        chk("q_m1_empty", 32'(q1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
